jk_seek_counter: RTL and testbench
==================================

Name: jk_seek_counter

Overview:
Target-seeking up/down counter built from a bank of JK flip-flops. The controller side computes J/K excitation per bit from current Q and the desired next Q. It accepts a target value over a valid/ready handshake and steps the flop bank one count per cycle until Q equals the target, then pulses done. Sits beside the existing JK flip-flop primitives as the driver that generates their J/K inputs.

Parameters:
WIDTH, 4, number of JK flip-flops (counter width, unsigned, >=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
tgt_valid  in  1  target offer
tgt_data  in  WIDTH  requested final counter value (unsigned)
tgt_ready  out  1  block can accept a target
hold  in  1  freeze stepping this cycle
q  out  WIDTH  flop bank Q
qn  out  WIDTH  flop bank Qn, always ~q
j  out  WIDTH  J excitation applied this cycle
k  out  WIDTH  K excitation applied this cycle
busy  out  1  seek in progress
dir  out  1  1 = counting up, 0 = counting down (valid while busy)
done  out  1  one-cycle pulse: target reached

Behaviour:
- Interface fixed: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, any state): q=0, qn=all ones, state IDLE, target reg=0, dir=0, done=0, busy=0. j=k=0 while in reset.
- States: IDLE, SEEK, DONE.
- IDLE: tgt_ready=1, busy=0, j=k=0. On tgt_valid&&tgt_ready, capture tgt_data into the target reg and set dir=(tgt_data>q).
  - If tgt_data==q: go to DONE. No flop changes.
  - Otherwise: go to SEEK.
- SEEK: tgt_ready=0, busy=1.
  - Each cycle with hold=0: nxt = dir ? q+1 : q-1.
  - Excitation per bit: j = ~q & nxt, k = q & ~nxt. Don't-cares are resolved to 0, so bits that do not change get J=K=0.
  - Flops update at the clock edge per the JK characteristic (00 hold, 01 reset, 10 set, 11 toggle). The 11 pattern never occurs.
  - When nxt==target, the transition to DONE happens on the same edge that loads q=target.
  - hold=1: j=k=0, q unchanged, state unchanged.
- DONE: done=1 for exactly one cycle, busy=0, tgt_ready=0, j=k=0. Next state is IDLE unconditionally.
- Latency: accept edge, then |target-q| SEEK cycles plus hold cycles, then 1 DONE cycle. Same value: accept, then DONE on the next cycle.
- No wrap: direction chosen by magnitude, so 0 -> 2^WIDTH-1 takes 2^WIDTH-1 steps. Arithmetic is WIDTH-bit unsigned and never overflows within a seek.
- tgt_valid while not IDLE is ignored (ready=0). No abort path other than rst_n.
- Reset mid-SEEK: q clears immediately (async), the seek is discarded, and no done pulse is produced.
- All outputs are registered or decoded from state/q only. There is no combinational path from tgt_valid to outputs except via state.

Decomposition:
- Shared package jk_pkg:
  - state enum {IDLE, SEEK, DONE}
  - JK command constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11
- Sub-module jk_ff_ar: single JK flip-flop with async active-low reset to Q=0, Qn=1. It is instantiated WIDTH times via generate.
- The excitation function ({J,K} from Q, Qnext) lives in jk_pkg so other blocks reuse it.

Test Plan:
- Reset mid-count: hold rst_n=0 during a SEEK at q=5 -> q=0, qn=4'hF immediately; busy=0, done never pulses; tgt_ready=1 after release.
- Count up: from q=0, offer tgt_data=3 -> tgt_ready drops; q steps 1,2,3 on three consecutive edges with dir=1; at q 1->2, j=4'b0010 and k=4'b0001; done pulses one cycle later; then IDLE.
- Count down: from q=3, tgt_data=0 -> q=2,1,0, dir=0; at 2->1, j=4'b0001 and k=4'b0010; one done pulse.
- Equal target: q=7, tgt_data=7 -> no q change, j=k=0, done pulses on the cycle after accept.
- Hold and ignored offers: seek 0->4 with hold=1 for 2 cycles at q=2 -> q stays 2 with j=k=0; a tgt_valid=1, tgt_data=9 presented mid-seek is ignored; completes at 4 after 6 SEEK cycles.
- Full range: from q=0, tgt_data=15 -> 15 steps; at 7->8, j=4'b1000 and k=4'b0111; never {J,K}=11 on any bit (assertion across all runs).

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for JK flip-flop based counters.
//   seek_state_e : controller state encoding (IDLE, SEEK, DONE)
//   JK_*         : {J,K} command patterns for a single JK flip-flop
//   jk_excite()  : minimal {J,K} excitation that moves one flop from
//                  q_cur to q_nxt, with don't-cares resolved to 0
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      DONE = 2'd2
   } seek_state_e;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // A bit that stays put gets HOLD, so the toggle pattern is never generated.
   function automatic logic [1:0] jk_excite(input logic q_cur, input logic q_nxt);
      logic [1:0] jk;
      case ({q_cur, q_nxt})
         2'b01:   jk = JK_SET;
         2'b10:   jk = JK_RST;
         default: jk = JK_HOLD;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_ff_ar.sv
// Single JK flip-flop with asynchronous active-low reset (Q=0, Qn=1).
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   j_i    : J input
//   k_i    : K input
//   q_o    : Q output
//   qn_o   : complementary output, always ~q_o
module jk_ff_ar
   import jk_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic j_i,
   input  logic k_i,
   output logic q_o,
   output logic qn_o
);

   logic q_q;
   logic q_d;

   // JK characteristic: hold, reset, set, toggle.
   always_comb begin
      q_d = q_q;
      case ({j_i, k_i})
         JK_HOLD: q_d = q_q;
         JK_RST:  q_d = 1'b0;
         JK_SET:  q_d = 1'b1;
         JK_TGL:  q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   // Flop storage with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o  = q_q;
   assign qn_o = ~q_q;

endmodule

// File: rtl/jk_seek_counter.sv
// Target-seeking up/down counter driving a bank of JK flip-flops.
// A target is accepted over a valid/ready handshake; the bank then steps
// one count per cycle toward it (direction chosen by magnitude, no wrap)
// and done pulses for one cycle once Q equals the target.
//   clk, rst_n           : clock, asynchronous active-low reset
//   tgt_valid/tgt_data   : target offer (accepted only in IDLE)
//   tgt_ready            : high in IDLE
//   hold                 : freeze stepping this cycle
//   q, qn                : flop bank outputs
//   j, k                 : excitation applied to the bank this cycle
//   busy, dir, done      : seek in progress, 1 = up, target-reached pulse
module jk_seek_counter
   import jk_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             tgt_ready,
   input  logic             hold,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             dir,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   seek_state_e      state_q, state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             dir_q, dir_d;

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] qn_s;
   logic [WIDTH-1:0] nxt_s;
   logic [WIDTH-1:0] j_s;
   logic [WIDTH-1:0] k_s;

   // Candidate next count; direction never wraps because it is chosen by magnitude.
   always_comb begin
      if (dir_q) begin
         nxt_s = q_s + ONE;
      end else begin
         nxt_s = q_s - ONE;
      end
   end

   // Per-bit excitation, only while actively stepping.
   always_comb begin
      j_s = '0;
      k_s = '0;
      if ((state_q == SEEK) && !hold) begin
         for (int b = 0; b < WIDTH; b++) begin
            {j_s[b], k_s[b]} = jk_excite(q_s[b], nxt_s[b]);
         end
      end else begin
         j_s = '0;
         k_s = '0;
      end
   end

   // Controller next-state logic.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      dir_d    = dir_q;
      case (state_q)
         IDLE: begin
            if (tgt_valid) begin
               target_d = tgt_data;
               dir_d    = (tgt_data > q_s);
               if (tgt_data == q_s) begin
                  state_d = DONE;
               end else begin
                  state_d = SEEK;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SEEK: begin
            // Leave on the same edge that loads the final count.
            if (!hold && (nxt_s == target_q)) begin
               state_d = DONE;
            end else begin
               state_d = SEEK;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         dir_q    <= dir_d;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bank
      jk_ff_ar u_ff (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .j_i    (j_s[g]),
         .k_i    (k_s[g]),
         .q_o    (q_s[g]),
         .qn_o   (qn_s[g])
      );
   end

   assign q         = q_s;
   assign qn        = qn_s;
   assign j         = j_s;
   assign k         = k_s;
   assign dir       = dir_q;
   assign tgt_ready = (state_q == IDLE);
   assign busy      = (state_q == SEEK);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_jk_seek_counter.sv
// Self-checking bench for jk_seek_counter (WIDTH=4). The reference model is
// just the current count, the last chosen direction and the rule "move one
// step toward the target per non-hold cycle".
module tb_jk_seek_counter;

   logic       clk;
   logic       rst_n;
   logic       tgt_valid;
   logic [3:0] tgt_data;
   logic       tgt_ready;
   logic       hold;
   logic [3:0] q, qn, j, k;
   logic       busy, dir, done;

   int pass_cnt;
   int chk_cnt;
   int done_cnt;
   int illegal_cnt;
   int busy_cycles;

   logic [3:0] model_q;
   logic       model_dir;
   logic [3:0] seen_j [16];
   logic [3:0] seen_k [16];

   jk_seek_counter #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgt_valid (tgt_valid),
      .tgt_data  (tgt_data),
      .tgt_ready (tgt_ready),
      .hold      (hold),
      .q         (q),
      .qn        (qn),
      .j         (j),
      .k         (k),
      .busy      (busy),
      .dir       (dir),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Background monitors sampled away from the active edge.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if ((j & k) !== 4'h0) illegal_cnt++;
   end

   function automatic logic [19:0] obs_vec();
      return {q, qn, j, k, busy, dir, done, tgt_ready};
   endfunction

   task automatic clear_seen();
      for (int i = 0; i < 16; i++) begin
         seen_j[i] = 4'bxxxx;
         seen_k[i] = 4'bxxxx;
      end
   endtask

   // Offer a target and follow the whole seek; entered and left at posedge+1.
   task automatic run_seek(input logic [3:0] tgt, input int hold_at,
                           input int hold_n, input bit junk);
      logic [3:0]  nxt, jexp, kexp;
      logic [19:0] exp_v;
      int          holds_left;
      int          guard;
      busy_cycles = 0;
      tgt_valid = 1'b1;
      tgt_data  = tgt;
      hold      = 1'b0;
      @(negedge clk);
      exp_v = {model_q, ~model_q, 4'h0, 4'h0, 1'b0, model_dir, 1'b0, 1'b1};
      chk_cnt++;
      if (obs_vec() !== exp_v) $display("FAIL idle_before_accept got=%h exp=%h", obs_vec(), exp_v);
      else pass_cnt++;
      @(posedge clk); #1;
      tgt_valid = junk;
      tgt_data  = junk ? 4'd9 : 4'd0;
      model_dir = (tgt > model_q);
      holds_left = hold_n;
      guard = 0;
      while ((model_q != tgt) && (guard < 64)) begin
         hold = ((int'(model_q) == hold_at) && (holds_left > 0));
         @(negedge clk);
         if (hold) begin
            nxt = model_q;
         end else if (model_dir) begin
            nxt = model_q + 4'd1;
         end else begin
            nxt = model_q - 4'd1;
         end
         jexp = nxt & ~model_q;
         kexp = model_q & ~nxt;
         exp_v = {model_q, ~model_q, jexp, kexp, 1'b1, model_dir, 1'b0, 1'b0};
         chk_cnt++;
         if (obs_vec() !== exp_v) $display("FAIL seek_step q=%0d got=%h exp=%h", model_q, obs_vec(), exp_v);
         else pass_cnt++;
         if (busy === 1'b1) busy_cycles++;
         if (!hold) begin
            seen_j[model_q] = j;
            seen_k[model_q] = k;
         end
         @(posedge clk); #1;
         if (hold) holds_left--;
         model_q = nxt;
         guard++;
      end
      chk_cnt++;
      if (guard >= 64) $display("FAIL seek_timeout got=%0d exp=<64", guard);
      else pass_cnt++;
      hold      = 1'b0;
      tgt_valid = 1'b0;
      @(negedge clk);
      exp_v = {tgt, ~tgt, 4'h0, 4'h0, 1'b0, model_dir, 1'b1, 1'b0};
      chk_cnt++;
      if (obs_vec() !== exp_v) $display("FAIL done_cycle got=%h exp=%h", obs_vec(), exp_v);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tgt_valid = 1'b0;
      tgt_data = 4'd0;
      hold = 1'b0;
      #3;
      chk_cnt++;
      if (obs_vec() !== {4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_state got=%h exp=%h", obs_vec(), {4'h0, 4'hF, 4'h0, 4'h0, 4'b0001});
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_q = 4'd0;
      model_dir = 1'b0;
   endtask

   task automatic test_count_up();
      clear_seen();
      run_seek(4'd3, -1, 0, 1'b0);
      chk_cnt++;
      if ({seen_j[1], seen_k[1]} !== {4'b0010, 4'b0001})
         $display("FAIL up_jk_1to2 got=%b exp=%b", {seen_j[1], seen_k[1]}, {4'b0010, 4'b0001});
      else pass_cnt++;
   endtask

   task automatic test_count_down();
      clear_seen();
      run_seek(4'd0, -1, 0, 1'b0);
      chk_cnt++;
      if ({seen_j[2], seen_k[2]} !== {4'b0001, 4'b0010})
         $display("FAIL down_jk_2to1 got=%b exp=%b", {seen_j[2], seen_k[2]}, {4'b0001, 4'b0010});
      else pass_cnt++;
   endtask

   task automatic test_equal();
      int d0;
      run_seek(4'd7, -1, 0, 1'b0);
      d0 = done_cnt;
      run_seek(4'd7, -1, 0, 1'b0);
      chk_cnt++;
      if ((done_cnt - d0) != 1) $display("FAIL equal_done_pulses got=%0d exp=1", done_cnt - d0);
      else pass_cnt++;
      chk_cnt++;
      if (busy_cycles != 0) $display("FAIL equal_busy_cycles got=%0d exp=0", busy_cycles);
      else pass_cnt++;
   endtask

   task automatic test_hold_ignore();
      run_seek(4'd0, -1, 0, 1'b0);
      run_seek(4'd4, 2, 2, 1'b1);
      chk_cnt++;
      if (busy_cycles != 6) $display("FAIL hold_seek_cycles got=%0d exp=6", busy_cycles);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({tgt_ready, busy, q} !== {1'b1, 1'b0, 4'd4})
         $display("FAIL hold_idle_after got=%b exp=%b", {tgt_ready, busy, q}, {1'b1, 1'b0, 4'd4});
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_full_range();
      run_seek(4'd0, -1, 0, 1'b0);
      clear_seen();
      run_seek(4'd15, -1, 0, 1'b0);
      chk_cnt++;
      if (busy_cycles != 15) $display("FAIL full_steps got=%0d exp=15", busy_cycles);
      else pass_cnt++;
      chk_cnt++;
      if ({seen_j[7], seen_k[7]} !== {4'b1000, 4'b0111})
         $display("FAIL full_jk_7to8 got=%b exp=%b", {seen_j[7], seen_k[7]}, {4'b1000, 4'b0111});
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         run_seek(4'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      end
   endtask

   task automatic test_reset_mid_seek();
      int d0;
      run_seek(4'd5, -1, 0, 1'b0);
      tgt_valid = 1'b1;
      tgt_data  = 4'd12;
      @(posedge clk); #1;
      tgt_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({busy, q} !== {1'b1, 4'd5}) $display("FAIL midreset_seek got=%b exp=%b", {busy, q}, {1'b1, 4'd5});
      else pass_cnt++;
      d0 = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({q, qn, j, k, busy, done} !== {4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0})
         $display("FAIL midreset_async got=%h exp=%h", {q, qn, j, k, busy, done}, {4'h0, 4'hF, 4'h0, 4'h0, 2'b00});
      else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({tgt_ready, busy, q} !== {1'b1, 1'b0, 4'd0})
         $display("FAIL midreset_release got=%b exp=%b", {tgt_ready, busy, q}, {1'b1, 1'b0, 4'd0});
      else pass_cnt++;
      chk_cnt++;
      if (done_cnt != d0) $display("FAIL midreset_no_done got=%0d exp=%0d", done_cnt, d0);
      else pass_cnt++;
      @(posedge clk); #1;
      model_q = 4'd0;
      model_dir = 1'b0;
   endtask

   initial begin
      pass_cnt = 0;
      chk_cnt = 0;
      done_cnt = 0;
      illegal_cnt = 0;
      busy_cycles = 0;
      test_reset();
      test_count_up();
      test_count_down();
      test_equal();
      test_hold_ignore();
      test_full_range();
      test_random();
      test_reset_mid_seek();
      chk_cnt++;
      if (illegal_cnt != 0) $display("FAIL jk_toggle_seen got=%0d exp=0", illegal_cnt);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
